// File: rtl/branch_resolve_queue_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue_if
//
// Purpose:
//   Predictor-update channel from the branch resolve queue to the frontend
//   predictors (BHT/BTB/RAS training).
//
// Handshake:
//   A record transfers on a rising clock edge where upd_valid && upd_ready.
//   The master holds upd_valid and the payload stable while upd_valid is high
//   and upd_ready is low. The one exception is overflow: the master may
//   discard its oldest record, so the payload then moves to the next-oldest
//   record. upd_ready may be driven independently of upd_valid.
//
// Signals:
//   upd_valid    master -> slave  head record available
//   upd_ready    slave  -> master slave accepts head this cycle
//   upd_pc       master -> slave  instruction PC (VLEN)
//   upd_target   master -> slave  target address (VLEN)
//   upd_taken    master -> slave  taken flag
//   upd_cf_type  master -> slave  control-flow type (CF_W)
//
// Modports:
//   master  used by branch_resolve_queue
//   slave   used by the frontend predictors
// -----------------------------------------------------------------------------
interface branch_resolve_queue_if #(
    parameter int unsigned VLEN = 64,
    parameter int unsigned CF_W = 3
);
    logic            upd_valid;
    logic            upd_ready;
    logic [VLEN-1:0] upd_pc;
    logic [VLEN-1:0] upd_target;
    logic            upd_taken;
    logic [CF_W-1:0] upd_cf_type;

    modport master (
        output upd_valid,
        input  upd_ready,
        output upd_pc,
        output upd_target,
        output upd_taken,
        output upd_cf_type
    );

    modport slave (
        input  upd_valid,
        output upd_ready,
        input  upd_pc,
        input  upd_target,
        input  upd_taken,
        input  upd_cf_type
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// Purpose:
//   Sits directly downstream of the branch unit.
//   - On a mispredict, it registers a one-cycle frontend redirect. The redirect
//     carries the full target PCC capability (metadata and cursor).
//   - It buffers predictor-update records in a small FIFO, so a busy predictor
//     never back-pressures execute. When the FIFO is full, the oldest record is
//     dropped in favour of the newest one.
//   - It drains the FIFO to the predictors over the upd interface (valid/ready).
//
// Parameters:
//   VLEN   virtual address width (taken from the core configuration)
//   PCLEN  capability PCC width; the cursor occupies bits [VLEN-1:0]
//   DEPTH  update FIFO entries; must be a power of two and at least 2
//   CF_W   width of the control-flow type; the value 0 means "not a CF instr"
//
// Ports:
//   clk_i, rst_ni             clock; synchronous active-low reset
//   flush_i                   pipeline flush; suppresses the redirect only
//   res_*_i                   resolved control-flow instruction from branch unit
//   redirect_valid_o          one-cycle pulse; fetch from redirect_pcc_o
//   redirect_pcc_o            new PCC; holds its value between pulses
//   upd                       predictor-update channel (master side)
//   upd_count_o               FIFO occupancy
//   upd_drop_o                one-cycle pulse when the oldest entry is discarded
//   mispredict_cnt_o          perf counter: number of redirect pulses
//   drop_cnt_o                perf counter: number of drops (saturating)
//
// Configuration:
//   CVA6_BRQ_PERF_EN  when defined, the two perf counters are instantiated.
//                     Otherwise mispredict_cnt_o and drop_cnt_o are tied to 0.
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
    parameter int unsigned VLEN  = 64,
    parameter int unsigned PCLEN = 128,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CF_W  = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,

    input  logic                       res_valid_i,
    input  logic [VLEN-1:0]            res_pc_i,
    input  logic [PCLEN-1:0]           res_target_i,
    input  logic                       res_is_taken_i,
    input  logic                       res_is_mispredict_i,
    input  logic [CF_W-1:0]            res_cf_type_i,

    output logic                       redirect_valid_o,
    output logic [PCLEN-1:0]           redirect_pcc_o,

    branch_resolve_queue_if.master     upd,

    output logic [$clog2(DEPTH):0]     upd_count_o,
    output logic                       upd_drop_o,
    output logic [31:0]                mispredict_cnt_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CF_W-1:0]  NO_CF    = '0;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target;
        logic            taken;
        logic [CF_W-1:0] cf_type;
    } entry_t;

    // ------------------------------------------------------------------
    // Redirect stage: a single flop stage.
    // ------------------------------------------------------------------
    logic             redirect_valid_q, redirect_valid_d;
    logic [PCLEN-1:0] redirect_pcc_q,   redirect_pcc_d;

    always_comb begin
        redirect_valid_d = res_valid_i && res_is_mispredict_i && !flush_i;
        // The PCC only updates on a pulse, so the frontend sees a stable value
        // between redirects.
        redirect_pcc_d   = redirect_valid_d ? res_target_i : redirect_pcc_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            redirect_valid_q <= 1'b0;
            redirect_pcc_q   <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pcc_q   <= redirect_pcc_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pcc_o   = redirect_pcc_q;

    // ------------------------------------------------------------------
    // Update FIFO
    // ------------------------------------------------------------------
    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               drop_q,   drop_d;

    logic   enq;
    logic   deq;
    logic   not_empty;
    logic   full;
    entry_t new_entry;
    entry_t head;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_CNT);

    // Training is kept whether or not the instruction mispredicted, and
    // whether or not a flush is in progress: the outcome itself is final.
    assign enq = res_valid_i && (res_cf_type_i != NO_CF);
    assign deq = not_empty && upd.upd_ready;

    always_comb begin
        new_entry         = '0;
        new_entry.pc      = res_pc_i;
        new_entry.target  = res_target_i[VLEN-1:0];
        new_entry.taken   = res_is_taken_i;
        new_entry.cf_type = res_cf_type_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = 1'b0;

        // Overflow: when full, an enqueue with no dequeue overwrites the
        // oldest slot. At full, wr_ptr == rd_ptr, so advancing both pointers
        // retires the oldest entry and makes the new entry the tail.
        if (enq && !deq && full) begin
            drop_d = 1'b1;
        end

        if (enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (deq || drop_d) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (enq && !deq && !full) begin
            count_d = count_q + 1'b1;
        end else if (deq && !enq) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // The storage needs no reset: the head outputs are gated by occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_ni && enq) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // The head is read only from registers, so no combinational path runs
    // from res_* to upd_*. The outputs read as zero while the FIFO is empty.
    always_comb begin
        head = '0;
        if (not_empty) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign upd.upd_valid   = not_empty;
    assign upd.upd_pc      = head.pc;
    assign upd.upd_target  = head.target;
    assign upd.upd_taken   = head.taken;
    assign upd.upd_cf_type = head.cf_type;
    assign upd_count_o     = count_q;
    assign upd_drop_o      = drop_q;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef CVA6_BRQ_PERF_EN
    logic [31:0] mis_cnt_q;
    logic [15:0] drop_cnt_q;

    // Each counter steps on the same edge that raises its pulse, so the
    // count and the pulse become visible in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mis_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (redirect_valid_d) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
            if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign mispredict_cnt_o = mis_cnt_q;
    assign drop_cnt_o       = drop_cnt_q;
`else
    assign mispredict_cnt_o = '0;
    assign drop_cnt_o       = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

    localparam int unsigned VLEN  = 64;
    localparam int unsigned PCLEN = 128;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CF_W  = 3;
    localparam int unsigned W     = 2 * VLEN + 1 + CF_W;

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   flush;
    logic                   res_valid;
    logic [VLEN-1:0]        res_pc;
    logic [PCLEN-1:0]       res_target;
    logic                   res_taken;
    logic                   res_mis;
    logic [CF_W-1:0]        res_cf;
    logic                   redirect_valid;
    logic [PCLEN-1:0]       redirect_pcc;
    logic [$clog2(DEPTH):0] upd_count;
    logic                   upd_drop;
    logic [31:0]            mis_cnt;
    logic [15:0]            drop_cnt;

    branch_resolve_queue_if #(.VLEN(VLEN), .CF_W(CF_W)) upd_if ();

    branch_resolve_queue #(
        .VLEN(VLEN), .PCLEN(PCLEN), .DEPTH(DEPTH), .CF_W(CF_W)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .flush_i             (flush),
        .res_valid_i         (res_valid),
        .res_pc_i            (res_pc),
        .res_target_i        (res_target),
        .res_is_taken_i      (res_taken),
        .res_is_mispredict_i (res_mis),
        .res_cf_type_i       (res_cf),
        .redirect_valid_o    (redirect_valid),
        .redirect_pcc_o      (redirect_pcc),
        .upd                 (upd_if.master),
        .upd_count_o         (upd_count),
        .upd_drop_o          (upd_drop),
        .mispredict_cnt_o    (mis_cnt),
        .drop_cnt_o          (drop_cnt)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Inputs change just after the rising edge, and outputs are sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [VLEN-1:0] pc, input logic [PCLEN-1:0] tgt,
                         input logic tk, input logic mis, input logic [CF_W-1:0] cf,
                         input logic fl);
        res_valid  = 1'b1;
        res_pc     = pc;
        res_target = tgt;
        res_taken  = tk;
        res_mis    = mis;
        res_cf     = cf;
        flush      = fl;
    endtask

    task automatic idle();
        res_valid = 1'b0;
        res_mis   = 1'b0;
        flush     = 1'b0;
        res_cf    = '0;
    endtask

    logic [W-1:0]     head_obs;
    logic [PCLEN-1:0] tgt1, tgt2, tgt3;
    assign head_obs = {upd_if.upd_pc, upd_if.upd_target, upd_if.upd_taken, upd_if.upd_cf_type};

    initial begin
        logic [VLEN-1:0] pc, tg;
        logic            tk;
        logic [CF_W-1:0] cf;
        int              n;
        int              cyc;

        rst_n = 1'b0;
        upd_if.upd_ready = 1'b0;
        res_pc = '0;
        res_target = '0;
        res_taken = 1'b0;
        idle();
        step();
        step();

        // Reset state
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pcc", redirect_pcc, 0);
        chk("rst_upd_valid", upd_if.upd_valid, 0);
        chk("rst_count", upd_count, 0);
        chk("rst_drop", upd_drop, 0);
        chk("rst_upd_pc", upd_if.upd_pc, 0);
        chk("rst_mis_cnt", mis_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        step();

        // T2: JALR mispredict; redirect carries the full capability
        tgt1 = {64'hC0DE_0000_1234_5678, 64'h0000_0000_8000_1000};
        drive(64'h8000_0FF0, tgt1, 1'b1, 1'b1, 3'd3, 1'b0);
        step();
        chk("t2_redirect_valid", redirect_valid, 1);
        chk("t2_redirect_pcc", redirect_pcc, tgt1);
        chk("t2_count", upd_count, 1);
        chk("t2_upd_valid", upd_if.upd_valid, 1);
        chk("t2_upd_pc", upd_if.upd_pc, 64'h8000_0FF0);
        chk("t2_upd_target", upd_if.upd_target, 64'h8000_1000);
        chk("t2_upd_taken", upd_if.upd_taken, 1);
        chk("t2_upd_cf", upd_if.upd_cf_type, 3);
        idle();
        step();
        chk("t2_pulse_end", redirect_valid, 0);
        chk("t2_pcc_hold", redirect_pcc, tgt1);
        // The same resolve under flush: no redirect, but training is kept
        drive(64'h8000_0FF0, tgt1, 1'b1, 1'b1, 3'd3, 1'b1);
        step();
        chk("t2_flush_no_redirect", redirect_valid, 0);
        chk("t2_flush_enqueued", upd_count, 2);
        // Back-to-back mispredicts: the pulse stays high and the PCC follows
        tgt2 = {64'hAAAA_0000_0000_0001, 64'h0000_0000_0000_0300};
        tgt3 = {64'hBBBB_0000_0000_0002, 64'h0000_0000_0000_0400};
        drive(64'h200, tgt2, 1'b1, 1'b1, 3'd2, 1'b0);
        step();
        chk("b2b_first_valid", redirect_valid, 1);
        chk("b2b_first_pcc", redirect_pcc, tgt2);
        drive(64'h204, tgt3, 1'b0, 1'b1, 3'd1, 1'b0);
        step();
        chk("b2b_second_valid", redirect_valid, 1);
        chk("b2b_second_pcc", redirect_pcc, tgt3);
        chk("b2b_count", upd_count, 4);
        idle();
        step();
        chk("b2b_pulse_end", redirect_valid, 0);
        // Drain in order
        upd_if.upd_ready = 1'b1;
        chk("drain0_pc", upd_if.upd_pc, 64'h8000_0FF0);
        step();
        chk("drain1_pc", upd_if.upd_pc, 64'h8000_0FF0);
        step();
        chk("drain2_pc", upd_if.upd_pc, 64'h200);
        chk("drain2_target", upd_if.upd_target, 64'h300);
        step();
        chk("drain3_pc", upd_if.upd_pc, 64'h204);
        chk("drain3_taken", upd_if.upd_taken, 0);
        step();
        chk("drain_empty_count", upd_count, 0);
        chk("drain_empty_valid", upd_if.upd_valid, 0);
        upd_if.upd_ready = 1'b0;

        // NoCF resolve does not enqueue
        drive(64'h300, '0, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        chk("nocf_count", upd_count, 0);
        chk("nocf_valid", upd_if.upd_valid, 0);
        idle();

        // T3: overflow drops the oldest entry
        for (int i = 0; i < 5; i++) begin
            drive(64'h100 + 64'(4 * i), {64'h0, 64'h1000 + 64'(i)}, 1'b0, 1'b0, 3'd1, 1'b0);
            step();
            chk("t3_drop", upd_drop, (i == 4) ? 1 : 0);
            chk("t3_count", upd_count, (i < 4) ? i + 1 : 4);
        end
        chk("t3_head", upd_if.upd_pc, 64'h104);
        idle();
        step();
        chk("t3_drop_pulse_end", upd_drop, 0);
        chk("t3_count_hold", upd_count, 4);
        chk("t3_head_stable", upd_if.upd_pc, 64'h104);

        // T4: enqueue and dequeue together at full
        upd_if.upd_ready = 1'b1;
        drive(64'h114, {64'h0, 64'h2000}, 1'b1, 1'b0, 3'd4, 1'b0);
        chk("t4_head_before", upd_if.upd_pc, 64'h104);
        step();
        idle();
        chk("t4_no_drop", upd_drop, 0);
        chk("t4_count", upd_count, 4);
        chk("t4_head_after", upd_if.upd_pc, 64'h108);
        step();
        chk("t4_d1", upd_if.upd_pc, 64'h10C);
        step();
        chk("t4_d2", upd_if.upd_pc, 64'h110);
        step();
        chk("t4_tail_pc", upd_if.upd_pc, 64'h114);
        chk("t4_tail_target", upd_if.upd_target, 64'h2000);
        chk("t4_tail_cf", upd_if.upd_cf_type, 4);
        step();
        chk("t4_empty", upd_count, 0);
        chk("t4_empty_pc_zero", upd_if.upd_pc, 0);
        upd_if.upd_ready = 1'b0;

        // A second overflow, for the drop counter
        for (int i = 0; i < 5; i++) begin
            drive(64'h500 + 64'(4 * i), '0, 1'b0, 1'b0, 3'd1, 1'b0);
            step();
        end
        chk("drop2_pulse", upd_drop, 1);
        idle();
        step();

        // T6: three mispredicts and two drops so far
`ifdef CVA6_BRQ_PERF_EN
        chk("t6_mis_cnt", mis_cnt, 3);
        chk("t6_drop_cnt", drop_cnt, 2);
`else
        chk("t6_mis_cnt_off", mis_cnt, 0);
        chk("t6_drop_cnt_off", drop_cnt, 0);
`endif

        // T1: reset in the middle of operation
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(64'h600 + 64'(4 * i), tgt2, 1'b1, (i == 2), 3'd1, 1'b0);
            step();
        end
        chk("t1_filled", upd_count, 3);
        chk("t1_redirect_before", redirect_valid, 1);
        // The reset edge must beat a mispredict that is also present
        rst_n = 1'b0;
        drive(64'h700, tgt3, 1'b1, 1'b1, 3'd1, 1'b0);
        step();
        chk("t1_count", upd_count, 0);
        chk("t1_valid", upd_if.upd_valid, 0);
        chk("t1_redirect", redirect_valid, 0);
        chk("t1_pcc", redirect_pcc, 0);
        chk("t1_mis_cnt", mis_cnt, 0);
        rst_n = 1'b1;
        idle();
        step();
        chk("t1_redirect_next", redirect_valid, 0);
        chk("t1_count_next", upd_count, 0);

        // T5: random ready; order must be preserved with no loss
        n = 0;
        cyc = 0;
        while (n < 1000 && cyc < 20000) begin
            upd_if.upd_ready = 1'($urandom_range(0, 1));
            chk("t5_count", upd_count, exp_q.size());
            chk("t5_valid", upd_if.upd_valid, (exp_q.size() != 0) ? 1 : 0);
            chk("t5_drop", upd_drop, 0);
            if (upd_if.upd_ready && exp_q.size() != 0) begin
                chk("t5_head", head_obs, exp_q[0]);
                void'(exp_q.pop_front());
            end
            // Resolve only while space remains, so no drop ever occurs
            if (exp_q.size() < DEPTH) begin
                pc = {$urandom, $urandom};
                tg = {$urandom, $urandom};
                tk = 1'($urandom_range(0, 1));
                cf = CF_W'($urandom_range(0, 4));
                drive(pc, {64'hFFFF_0000_FFFF_0000, tg}, tk, 1'b0, cf, 1'b0);
                if (cf != 0) begin
                    exp_q.push_back({pc, tg, tk, cf});
                    n++;
                end
            end else begin
                idle();
            end
            step();
            cyc++;
        end
        idle();
        chk("t5_budget", n, 1000);
        upd_if.upd_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            chk("t5_tail_head", head_obs, exp_q[0]);
            void'(exp_q.pop_front());
            step();
            cyc++;
        end
        chk("t5_final_count", upd_count, 0);
        chk("t5_final_redirect", redirect_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
